// File: rtl/break_sequencer.sv
// Data-break sequencer: arbitrates NUM_CHAN break requests at the CPU's F0 point and steals
// one BS0..BS3 memory cycle per word. Define BREAK_THREE_CYCLE_EN to add the WC/CA passes.
module break_sequencer #(
    parameter int NUM_CHAN    = 4,
    parameter int BURST_MAX   = 1,
    parameter int ROUND_ROBIN = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_at_f0,
    input  logic [NUM_CHAN-1:0] break_req,
    input  logic [NUM_CHAN-1:0] to_mem,
    input  logic [NUM_CHAN-1:0] three_cycle,
    input  logic [11:0]         mem_rdata,
    output logic                break_in_prog,
    output logic [NUM_CHAN-1:0] grant,
    output logic                mem_we,
    output logic [11:0]         mem_wdata,
    output logic [1:0]          phase,
    output logic [NUM_CHAN-1:0] ack,
    output logic                wc_ovf,
    output logic [2:0]          state
);
    localparam int IDX_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

`ifdef BREAK_THREE_CYCLE_EN
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_BS0  = 4'd1,
        S_BS1  = 4'd2,
        S_BS2  = 4'd3,
        S_BS3  = 4'd4,
        S_WC0  = 4'd5,
        S_WC1  = 4'd6,
        S_WC2  = 4'd7,
        S_WC3  = 4'd8,
        S_CA0  = 4'd9,
        S_CA1  = 4'd10,
        S_CA2  = 4'd11,
        S_CA3  = 4'd12
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BS0  = 3'd1,
        S_BS1  = 3'd2,
        S_BS2  = 3'd3,
        S_BS3  = 3'd4
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [NUM_CHAN-1:0] grant_q, grant_d;
    logic                dir_q, dir_d;
    logic [3:0]          burst_q, burst_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
`ifdef BREAK_THREE_CYCLE_EN
    logic                tc_q, tc_d;
    logic                ovf_q, ovf_d;
`else
    logic                unused_inputs;
    assign unused_inputs = ^{three_cycle, mem_rdata};
`endif

    // Arbitration: rotate the request vector so the search always starts at bit 0.
    logic [IDX_W-1:0]      base;
    logic [2*NUM_CHAN-1:0] req_dbl;
    logic [NUM_CHAN-1:0]   req_rot;
    logic [IDX_W-1:0]      win_off;
    logic [IDX_W:0]        win_sum;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      win_next;
    logic [NUM_CHAN-1:0]   win_1h;
    logic                  grant_go;
    logic                  req_hold;
    logic                  more_words;

    assign base    = (ROUND_ROBIN != 0) ? ptr_q : '0;
    assign req_dbl = {break_req, break_req} >> base;
    assign req_rot = req_dbl[NUM_CHAN-1:0];

    always_comb begin
        win_off = '0;
        for (int j = NUM_CHAN - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                win_off = IDX_W'(j);
            end
        end
    end

    assign win_sum  = {1'b0, base} + {1'b0, win_off};
    assign win_idx  = (win_sum >= (IDX_W+1)'(NUM_CHAN)) ?
                      IDX_W'(win_sum - (IDX_W+1)'(NUM_CHAN)) : win_sum[IDX_W-1:0];
    assign win_next = (win_idx == IDX_W'(NUM_CHAN - 1)) ? '0 : win_idx + 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_win
            assign win_1h[gi] = (win_idx == IDX_W'(gi));
        end
    endgenerate

    // Grants are only taken while out of reset so every output is quiet under reset.
    assign grant_go   = cpu_at_f0 & (|break_req) & ~reset;
    assign req_hold   = |(break_req & grant_q);
    assign more_words = ({1'b0, burst_q} + 5'd1) < 5'(BURST_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            dir_q   <= 1'b0;
            burst_q <= '0;
            ptr_q   <= '0;
`ifdef BREAK_THREE_CYCLE_EN
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            dir_q   <= dir_d;
            burst_q <= burst_d;
            ptr_q   <= ptr_d;
`ifdef BREAK_THREE_CYCLE_EN
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        dir_d   = dir_q;
        burst_d = burst_q;
        ptr_d   = ptr_q;
`ifdef BREAK_THREE_CYCLE_EN
        tc_d    = tc_q;
        ovf_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_go) begin
                    grant_d = win_1h;
                    dir_d   = |(to_mem & win_1h);
                    burst_d = '0;
                    ptr_d   = win_next;
`ifdef BREAK_THREE_CYCLE_EN
                    tc_d    = |(three_cycle & win_1h);
                    state_d = (|(three_cycle & win_1h)) ? S_WC0 : S_BS0;
`else
                    state_d = S_BS0;
`endif
                end
            end
            S_BS0: state_d = S_BS1;
            S_BS1: state_d = S_BS2;
            S_BS2: state_d = S_BS3;
            S_BS3: begin
                // Another word only if the owner still asks and the burst has room.
                if (req_hold && more_words) begin
                    burst_d = burst_q + 4'd1;
`ifdef BREAK_THREE_CYCLE_EN
                    state_d = tc_q ? S_WC0 : S_BS0;
`else
                    state_d = S_BS0;
`endif
                end else begin
                    burst_d = '0;
                    grant_d = '0;
                    dir_d   = 1'b0;
`ifdef BREAK_THREE_CYCLE_EN
                    tc_d    = 1'b0;
`endif
                    state_d = S_IDLE;
                end
            end
`ifdef BREAK_THREE_CYCLE_EN
            S_WC0: state_d = S_WC1;
            S_WC1: state_d = S_WC2;
            S_WC2: begin
                state_d = S_WC3;
                ovf_d   = (mem_rdata == 12'o7777);
            end
            S_WC3: state_d = S_CA0;
            S_CA0: state_d = S_CA1;
            S_CA1: state_d = S_CA2;
            S_CA2: state_d = S_CA3;
            S_CA3: state_d = S_BS0;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // External state code: 0 = idle, 1..4 = step 0..3 of the current pass (phase names the pass).
    always_comb begin
        break_in_prog = (state_q != S_IDLE) || grant_go;
        grant         = grant_q;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        phase         = 2'd0;
        ack           = '0;
        wc_ovf        = 1'b0;
        state         = 3'd0;
        case (state_q)
            S_BS0: state = 3'd1;
            S_BS1: state = 3'd2;
            S_BS2: begin
                state  = 3'd3;
                mem_we = dir_q;
            end
            S_BS3: begin
                state = 3'd4;
                ack   = grant_q;
            end
`ifdef BREAK_THREE_CYCLE_EN
            S_WC0: begin
                state = 3'd1;
                phase = 2'd1;
            end
            S_WC1: begin
                state = 3'd2;
                phase = 2'd1;
            end
            S_WC2: begin
                state     = 3'd3;
                phase     = 2'd1;
                mem_we    = 1'b1;
                mem_wdata = mem_rdata + 12'd1;
            end
            S_WC3: begin
                state  = 3'd4;
                phase  = 2'd1;
                wc_ovf = ovf_q;
            end
            S_CA0: begin
                state = 3'd1;
                phase = 2'd2;
            end
            S_CA1: begin
                state = 3'd2;
                phase = 2'd2;
            end
            S_CA2: begin
                state     = 3'd3;
                phase     = 2'd2;
                mem_we    = 1'b1;
                mem_wdata = mem_rdata + 12'd1;
            end
            S_CA3: begin
                state = 3'd4;
                phase = 2'd2;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_break_sequencer.sv
// Bench for break_sequencer: a fixed-priority single-word instance and a round-robin
// three-word-burst instance, directed scenarios plus random traffic against a timeline model.
module tb_break_sequencer;
    localparam int N    = 4;
    localparam int NDUT = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NDUT-1:0]            f0;
    logic [NDUT-1:0][N-1:0]     req;
    logic [N-1:0]               to_mem;
    logic [N-1:0]               three_cycle;
    logic [11:0]                mem_rdata;
    logic [NDUT-1:0]            bip;
    logic [NDUT-1:0]            mem_we;
    logic [NDUT-1:0]            wc_ovf;
    logic [NDUT-1:0][N-1:0]     grant;
    logic [NDUT-1:0][N-1:0]     ack;
    logic [NDUT-1:0][11:0]      wdata;
    logic [NDUT-1:0][1:0]       phase;
    logic [NDUT-1:0][2:0]       st;

    int n_check = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    break_sequencer #(.NUM_CHAN(N), .BURST_MAX(1), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .reset(reset), .cpu_at_f0(f0[0]), .break_req(req[0]),
        .to_mem(to_mem), .three_cycle(three_cycle), .mem_rdata(mem_rdata),
        .break_in_prog(bip[0]), .grant(grant[0]), .mem_we(mem_we[0]),
        .mem_wdata(wdata[0]), .phase(phase[0]), .ack(ack[0]),
        .wc_ovf(wc_ovf[0]), .state(st[0])
    );

    break_sequencer #(.NUM_CHAN(N), .BURST_MAX(3), .ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .reset(reset), .cpu_at_f0(f0[1]), .break_req(req[1]),
        .to_mem(to_mem), .three_cycle(three_cycle), .mem_rdata(mem_rdata),
        .break_in_prog(bip[1]), .grant(grant[1]), .mem_we(mem_we[1]),
        .mem_wdata(wdata[1]), .phase(phase[1]), .ack(ack[1]),
        .wc_ovf(wc_ovf[1]), .state(st[1])
    );

    // Reference model: a grant is a timeline of t cycles since the first break cycle;
    // words are 4 cycles long (12 with the three-cycle passes).
    int          m_busy [NDUT];
    int          m_ch   [NDUT];
    int          m_t    [NDUT];
    int          m_ptr  [NDUT];
    bit          m_dir  [NDUT];
    bit          m_tc   [NDUT];
    logic [11:0] m_prev_rd;

    function automatic int bmax_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int wlen(int k);
        return m_tc[k] ? 12 : 4;
    endfunction

    function automatic int pick(int k);
        int base;
        base = (k == 1) ? m_ptr[k] : 0;
        for (int j = 0; j < N; j++) begin
            if (req[k][(base + j) % N]) return (base + j) % N;
        end
        return 0;
    endfunction

    always @(posedge clk) begin : model
        int w;
        for (int k = 0; k < NDUT; k++) begin
            if (reset) begin
                m_busy[k] <= 0;
                m_ptr[k]  <= 0;
                m_t[k]    <= 0;
            end else if (m_busy[k] == 0) begin
                if (f0[k] && req[k] != '0) begin
                    w = pick(k);
                    m_busy[k] <= 1;
                    m_ch[k]   <= w;
                    m_t[k]    <= 0;
                    m_dir[k]  <= to_mem[w];
                    m_ptr[k]  <= (w + 1) % N;
`ifdef BREAK_THREE_CYCLE_EN
                    m_tc[k]   <= three_cycle[w];
`else
                    m_tc[k]   <= 1'b0;
`endif
                end
            end else if ((m_t[k] % wlen(k)) == wlen(k) - 1) begin
                if (req[k][m_ch[k]] && (m_t[k] / wlen(k) + 1) < bmax_of(k))
                    m_t[k] <= m_t[k] + 1;
                else
                    m_busy[k] <= 0;
            end else begin
                m_t[k] <= m_t[k] + 1;
            end
        end
        m_prev_rd <= mem_rdata;
    end

    // {bip, grant, mem_we, wdata, phase, ack, wc_ovf, state}
    function automatic logic [27:0] expect_out(int k);
        logic           e_bip, e_we, e_ovf;
        logic [N-1:0]   e_grant, e_ack;
        logic [11:0]    e_wd;
        logic [1:0]     e_ph;
        logic [2:0]     e_st;
        int             pos, pass;
        e_bip = 1'b0; e_we = 1'b0; e_ovf = 1'b0; e_grant = '0; e_ack = '0;
        e_wd = '0; e_ph = 2'd0; e_st = 3'd0;
        if (m_busy[k] == 0) begin
            e_bip = !reset && f0[k] && (req[k] != '0);
        end else begin
            e_bip   = 1'b1;
            e_grant = N'(1) << m_ch[k];
            pos     = m_t[k] % 4;
            pass    = m_tc[k] ? (m_t[k] % 12) / 4 : 2;
            e_st    = 3'(pos + 1);
            e_ph    = (pass == 0) ? 2'd1 : (pass == 1) ? 2'd2 : 2'd0;
            if (pass == 2) begin
                if (pos == 2) e_we = m_dir[k];
                if (pos == 3) e_ack = e_grant;
            end else begin
                if (pos == 2) begin
                    e_we = 1'b1;
                    e_wd = mem_rdata + 12'd1;
                end
                if (pass == 0 && pos == 3) e_ovf = (m_prev_rd == 12'o7777);
            end
        end
        return {e_bip, e_grant, e_we, e_wd, e_ph, e_ack, e_ovf, e_st};
    endfunction

    task automatic idle_inputs();
        req = '0; f0 = '0; to_mem = '0; three_cycle = '0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        logic [27:0] got;
        @(negedge clk);
        reset = 1'b1; req[0] = 4'b1111; req[1] = 4'b1111; f0 = 2'b11; to_mem = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            got = {bip[k], grant[k], mem_we[k], wdata[k], phase[k], ack[k], wc_ovf[k], st[k]};
            n_check++;
            if (got !== 28'd0) $display("FAIL reset dut%0d: got %h expected 0", k, got);
            else n_pass++;
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_write();
        int bip_cnt = 0;
        @(negedge clk);
        req[0] = 4'b0010; to_mem = 4'b0010; f0[0] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) f0[0] = 1'b0;
            if (c == 5) req[0] = '0;
            #1;
            if (bip[0] === 1'b1) bip_cnt++;
            n_check++;
            if (mem_we[0] !== (c == 3)) $display("FAIL single_we c%0d: got %b expected %b", c, mem_we[0], (c == 3));
            else n_pass++;
            if (c == 1) begin
                n_check++;
                if (grant[0] !== 4'b0010) $display("FAIL single_grant: got %b expected 0010", grant[0]);
                else n_pass++;
            end
            if (c == 4) begin
                n_check++;
                if (ack[0] !== 4'b0010) $display("FAIL single_ack: got %b expected 0010", ack[0]);
                else n_pass++;
            end
            if (c == 5) begin
                n_check++;
                if (st[0] !== 3'd0) $display("FAIL single_idle: got %0d expected 0", st[0]);
                else n_pass++;
            end
        end
        n_check++;
        if (bip_cnt != 5) $display("FAIL single_bip_len: got %0d expected 5", bip_cnt);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        req[0] = 4'b0101; f0[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) req[0] = 4'b0100;
            if (c == 10) begin req[0] = '0; f0[0] = 1'b0; end
            #1;
            if (c == 1) begin
                n_check++;
                if (grant[0] !== 4'b0001) $display("FAIL prio_first: got %b expected 0001", grant[0]);
                else n_pass++;
            end
            if (c == 6) begin
                n_check++;
                if (grant[0] !== 4'b0100) $display("FAIL prio_second: got %b expected 0100", grant[0]);
                else n_pass++;
            end
            if (c == 9) begin
                n_check++;
                if (ack[0] !== 4'b0100) $display("FAIL prio_ack: got %b expected 0100", ack[0]);
                else n_pass++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req[1] = 4'b0001; f0[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 3) begin req[1] = '0; f0[1] = 1'b0; end
            if (c == 5) begin req[1] = 4'b0101; f0[1] = 1'b1; end
            if (c == 7) begin req[1] = '0; f0[1] = 1'b0; end
            #1;
            if (c == 1) begin
                n_check++;
                if (grant[1] !== 4'b0001) $display("FAIL rr_first: got %b expected 0001", grant[1]);
                else n_pass++;
            end
            if (c == 4) begin
                n_check++;
                if (ack[1] !== 4'b0001) $display("FAIL rr_drop_ack: got %b expected 0001", ack[1]);
                else n_pass++;
            end
            if (c == 5) begin
                n_check++;
                if (st[1] !== 3'd0) $display("FAIL rr_drop_end: got %0d expected 0", st[1]);
                else n_pass++;
            end
            if (c == 6) begin
                n_check++;
                if (grant[1] !== 4'b0100) $display("FAIL rr_rotate: got %b expected 0100", grant[1]);
                else n_pass++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_burst();
        int ack_cnt = 0;
        @(negedge clk);
        req[1] = 4'b1000; f0[1] = 1'b1; to_mem = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 14) begin req[1] = '0; f0[1] = 1'b0; end
            #1;
            if (c >= 1 && c <= 12 && ack[1] === 4'b1000) ack_cnt++;
            if (c == 13) begin
                n_check++;
                if ({st[1], grant[1]} !== 7'd0) $display("FAIL burst_gap: got state %0d grant %b expected 0 0000", st[1], grant[1]);
                else n_pass++;
            end
            if (c == 14) begin
                n_check++;
                if (grant[1] !== 4'b1000) $display("FAIL burst_regrant: got %b expected 1000", grant[1]);
                else n_pass++;
            end
            if (c == 18) begin
                n_check++;
                if (st[1] !== 3'd0) $display("FAIL burst_end: got %0d expected 0", st[1]);
                else n_pass++;
            end
        end
        n_check++;
        if (ack_cnt != 3) $display("FAIL burst_acks: got %0d expected 3", ack_cnt);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_f0_wait();
        @(negedge clk);
        req[0] = 4'b0010; f0[0] = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 10) f0[0] = 1'b1;
            if (c == 11) f0[0] = 1'b0;
            if (c == 12) req[0] = '0;
            #1;
            if (c < 10) begin
                n_check++;
                if ({bip[0], grant[0]} !== 5'd0) $display("FAIL f0_wait c%0d: got bip %b grant %b expected 0 0000", c, bip[0], grant[0]);
                else n_pass++;
            end
            if (c == 11) begin
                n_check++;
                if (grant[0] !== 4'b0010) $display("FAIL f0_release: got %b expected 0010", grant[0]);
                else n_pass++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [27:0] got;
        @(negedge clk);
        req[0] = 4'b0001; f0[0] = 1'b1; to_mem = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) f0[0] = 1'b0;
            #1;
            if (c == 2) begin
                n_check++;
                if (st[0] !== 3'd2) $display("FAIL rstmid_bs1: got %0d expected 2", st[0]);
                else n_pass++;
                reset = 1'b1;
            end
            if (c >= 3) begin
                got = {bip[0], grant[0], mem_we[0], wdata[0], phase[0], ack[0], wc_ovf[0], st[0]};
                n_check++;
                if (got !== 28'd0) $display("FAIL rstmid c%0d: got %h expected 0", c, got);
                else n_pass++;
                reset = 1'b0;
                req[0] = '0;
            end
        end
        idle_inputs();
    endtask

`ifdef BREAK_THREE_CYCLE_EN
    task automatic test_three_cycle();
        @(negedge clk);
        req[0] = 4'b0001; three_cycle = 4'b0001; to_mem = 4'b0000; f0[0] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) f0[0] = 1'b0;
            if (c == 3) mem_rdata = 12'o7777;
            if (c == 7) mem_rdata = 12'o0123;
            if (c == 10) req[0] = '0;
            #1;
            if (c == 1 || c == 5 || c == 9) begin
                n_check++;
                if ({st[0], phase[0]} !== {3'd1, (c == 1) ? 2'd1 : (c == 5) ? 2'd2 : 2'd0})
                    $display("FAIL tc_pass c%0d: got state %0d phase %0d", c, st[0], phase[0]);
                else n_pass++;
            end
            if (c == 3) begin
                n_check++;
                if ({mem_we[0], wdata[0]} !== {1'b1, 12'o0000}) $display("FAIL tc_wc_wrap: got we %b data %o expected 1 0000", mem_we[0], wdata[0]);
                else n_pass++;
            end
            if (c == 4 || c == 8) begin
                n_check++;
                if (wc_ovf[0] !== (c == 4)) $display("FAIL tc_ovf c%0d: got %b expected %b", c, wc_ovf[0], (c == 4));
                else n_pass++;
            end
            if (c == 7) begin
                n_check++;
                if ({mem_we[0], wdata[0]} !== {1'b1, 12'o0124}) $display("FAIL tc_ca_inc: got we %b data %o expected 1 0124", mem_we[0], wdata[0]);
                else n_pass++;
            end
            if (c == 12) begin
                n_check++;
                if (ack[0] !== 4'b0001) $display("FAIL tc_ack: got %b expected 0001", ack[0]);
                else n_pass++;
            end
        end
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        logic [27:0]            got, exp_v;
        logic [NDUT-1:0][N-1:0] last_ack;
        last_ack = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc > 0) @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                for (int c = 0; c < N; c++) begin
                    if (req[k][c]) begin
                        if (last_ack[k][c] && $urandom_range(1, 0) == 1) req[k][c] = 1'b0;
                    end else if ($urandom_range(3, 0) == 0) begin
                        req[k][c] = 1'b1;
                    end
                end
                f0[k] = ($urandom_range(1, 0) == 1);
            end
            to_mem      = N'($urandom);
            three_cycle = N'($urandom);
            mem_rdata   = ($urandom_range(3, 0) == 0) ? 12'o7777 : 12'($urandom);
            #1;
            for (int k = 0; k < NDUT; k++) begin
                got   = {bip[k], grant[k], mem_we[k], wdata[k], phase[k], ack[k], wc_ovf[k], st[k]};
                exp_v = expect_out(k);
                n_check++;
                if (got !== exp_v) $display("FAIL random dut%0d cyc%0d: got %h expected %h", k, cyc, got, exp_v);
                else n_pass++;
                last_ack[k] = ack[k];
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        test_reset();
        test_single_write();
        test_fixed_priority();
        test_round_robin();
        test_burst();
        test_f0_wait();
        test_reset_mid();
`ifdef BREAK_THREE_CYCLE_EN
        test_three_cycle();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end
endmodule
